prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter INSTR_W, default 32, SHALL set the instruction word width.
REQ-002 Parameter ADRS_W, default 11, SHALL set the instruction-memory address width.
REQ-003 Parameter DEPTH, default 2048, SHALL set the number of writable words; DEPTH <= 2**ADRS_W.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on rising edge.
REQ-005 resetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 cfg_start_adrs  in  ADRS_W  SHALL give the first write address; sampled when a load begins.
REQ-007 s_valid / s_ready  in / out  1  SHALL form the program-word stream handshake; transfer when both are high.
REQ-008 s_data  in  INSTR_W  SHALL carry one program word per transfer.
REQ-009 s_last  in  1  SHALL mark the final word of a program.
REQ-010 halt_req  in  1  SHALL stop the CPU and return the loader to IDLE.
REQ-011 w_enable, w_adrs[ADRS_W], w_instruction[INSTR_W]  out  SHALL be the instruction-memory write port.
REQ-012 cpu_en  out  1  SHALL enable the CPU pipeline.
REQ-013 busy, done, err  out  1 each  SHALL flag loading, program running, and error.

Function
REQ-014 The block SHALL implement states IDLE, LOAD, RUN and ERR.
REQ-015 s_ready SHALL be 1 in IDLE and LOAD and 0 in RUN and ERR.
REQ-016 IDLE -> LOAD on the first transfer; w_adrs for that word SHALL equal cfg_start_adrs.
REQ-017 Each transfer accepted at edge N SHALL produce w_enable=1 with registered address and data for exactly the cycle after edge N.
REQ-018 Write latency SHALL be 1 cycle; back-to-back transfers SHALL give back-to-back writes with no bubbles.
REQ-019 After each write, the address SHALL increment by 1.
REQ-020 A transfer whose address would be >= DEPTH SHALL NOT be written; the block SHALL go to ERR with err=1.
REQ-021 Accepting s_last SHALL move LOAD -> RUN; cpu_en SHALL rise the cycle after the last write.
REQ-022 In RUN, cpu_en=1 and done=1; w_enable SHALL stay 0.
REQ-023 halt_req=1 in any state SHALL go to IDLE next edge with cpu_en=0 and err cleared.
REQ-024 halt_req SHALL take priority over a same-cycle transfer, and that word SHALL be dropped.
REQ-025 busy SHALL be 1 exactly while in LOAD.
REQ-026 A single-word program (s_last on the first transfer) SHALL write one word and enter RUN.

Reset
REQ-027 While resetn=0, the block SHALL be in IDLE with every output at 0 except s_ready=1, and the address counter at 0.
REQ-028 Reset asserted mid-LOAD SHALL abandon the load with no partial write after deassertion.

Configuration
REQ-029 With PROG_LOADER_CSUM_EN defined:
- the s_last word SHALL be a checksum, not an instruction, and SHALL NOT be written;
- the checksum is the modulo-2**INSTR_W sum of all prior program words;
- a match SHALL enter RUN; a mismatch SHALL enter ERR with cpu_en=0.
REQ-030 Without PROG_LOADER_CSUM_EN, the s_last word SHALL be written like any other word and no sum logic SHALL exist.

Structure
REQ-031 Package prog_loader_pkg SHALL hold the state enum and the default INSTR_W, ADRS_W and DEPTH constants.
REQ-032 The checksum accumulator SHALL be the sub-module prog_loader_csum, instantiated only under PROG_LOADER_CSUM_EN.

Verification
REQ-033 Start 1, words 0xE0000C07, 0xE0230007, 0xC07FF003 (last on third):
- writes at addresses 1, 2, 3 on consecutive cycles;
- cpu_en=1 one cycle after the adrs-3 write.
REQ-034 Start 2045, DEPTH 2048, four words: addresses 2045-2047 written; fourth dropped; err=1; cpu_en=0.
REQ-035 s_valid toggled every other cycle: every write follows its transfer by exactly 1 cycle; addresses contiguous.
REQ-036 resetn pulsed low after two words: all outputs return to 0 (s_ready=1) asynchronously; a new load restarts at cfg_start_adrs.
REQ-037 halt_req and s_valid high together in LOAD: no write; state IDLE; cpu_en=0.
REQ-038 With PROG_LOADER_CSUM_EN, words 0x1, 0x2 and last 0x3: RUN. Last 0x4 instead: ERR, and the checksum word is never written.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared state encoding and default geometry for the program loader.
package prog_loader_pkg;
    localparam int INSTR_W_DEF = 32;
    localparam int ADRS_W_DEF  = 11;
    localparam int DEPTH_DEF   = 2048;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_ERR
    } state_t;
endpackage

// File: rtl/prog_loader_csum.sv
// Running modulo-2**W sum of program words; clr wins unless a word is added the same cycle.
module prog_loader_csum #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         add,
    input  logic [W-1:0] data,
    output logic [W-1:0] sum
);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum <= '0;
        end else if (add) begin
            // a word added on the clearing cycle starts a fresh sum
            sum <= (clr ? '0 : sum) + data;
        end else if (clr) begin
            sum <= '0;
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Streams program words into instruction memory, then enables the CPU.
// PROG_LOADER_CSUM_EN: treat the s_last word as a checksum of the preceding words.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int ADRS_W  = ADRS_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [ADRS_W-1:0]  cfg_start_adrs,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [INSTR_W-1:0] s_data,
    input  logic               s_last,
    input  logic               halt_req,
    output logic               w_enable,
    output logic [ADRS_W-1:0]  w_adrs,
    output logic [INSTR_W-1:0] w_instruction,
    output logic               cpu_en,
    output logic               busy,
    output logic               done,
    output logic               err
);
    // one extra bit so stepping past the top of memory is visible as out of range
    localparam logic [ADRS_W:0] DEPTH_L = (ADRS_W+1)'(DEPTH);

    state_t          state;
    logic [ADRS_W:0] adrs_cnt;
    logic [ADRS_W:0] cur_adrs;
    logic            in_range;
    logic            xfer;
    logic            csum_word;
    logic            csum_ok;

    assign s_ready  = (state == ST_IDLE) || (state == ST_LOAD);
    assign xfer     = s_valid && s_ready;
    assign cur_adrs = (state == ST_IDLE) ? {1'b0, cfg_start_adrs} : adrs_cnt;
    assign in_range = cur_adrs < DEPTH_L;

`ifdef PROG_LOADER_CSUM_EN
    logic [INSTR_W-1:0] sum;
    logic               sum_clr;
    logic               sum_add;

    assign sum_clr   = halt_req || (state != ST_LOAD);
    assign sum_add   = xfer && !halt_req && !s_last && in_range;
    assign csum_word = s_last;
    assign csum_ok   = (s_data == sum);

    prog_loader_csum #(.W(INSTR_W)) u_csum (
        .clk    (clk),
        .resetn (resetn),
        .clr    (sum_clr),
        .add    (sum_add),
        .data   (s_data),
        .sum    (sum)
    );
`else
    assign csum_word = 1'b0;
    assign csum_ok   = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            adrs_cnt      <= '0;
            w_enable      <= 1'b0;
            w_adrs        <= '0;
            w_instruction <= '0;
            cpu_en        <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            w_enable <= 1'b0;
            if (halt_req) begin
                state    <= ST_IDLE;
                adrs_cnt <= '0;
                cpu_en   <= 1'b0;
                done     <= 1'b0;
                busy     <= 1'b0;
                err      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_LOAD: begin
                        if (xfer) begin
                            if (csum_word) begin
                                busy  <= 1'b0;
                                state <= csum_ok ? ST_RUN : ST_ERR;
                                err   <= !csum_ok;
                            end else if (!in_range) begin
                                busy  <= 1'b0;
                                state <= ST_ERR;
                                err   <= 1'b1;
                            end else begin
                                w_enable      <= 1'b1;
                                w_adrs        <= cur_adrs[ADRS_W-1:0];
                                w_instruction <= s_data;
                                adrs_cnt      <= cur_adrs + 1'b1;
                                state         <= s_last ? ST_RUN : ST_LOAD;
                                busy          <= !s_last;
                            end
                        end
                    end
                    // CPU comes up the cycle after entry, i.e. after the final write
                    ST_RUN: begin
                        cpu_en <= 1'b1;
                        done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed tables, hand sequences and random traffic vs. a model.
module tb_prog_loader;
    localparam int IW  = 32;
    localparam int AW  = 11;
    localparam int DEP = 2048;
`ifdef PROG_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [AW-1:0] cfg_start_adrs = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [IW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          halt_req = 1'b0;
    logic          w_enable;
    logic [AW-1:0] w_adrs;
    logic [IW-1:0] w_instruction;
    logic          cpu_en, busy, done, err;

    always #5 clk = ~clk;

    prog_loader #(.INSTR_W(IW), .ADRS_W(AW), .DEPTH(DEP)) dut (
        .clk(clk), .resetn(resetn), .cfg_start_adrs(cfg_start_adrs),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .halt_req(halt_req), .w_enable(w_enable), .w_adrs(w_adrs),
        .w_instruction(w_instruction), .cpu_en(cpu_en), .busy(busy),
        .done(done), .err(err)
    );

    typedef enum {M_IDLE, M_LOAD, M_RUN, M_ERR} mmode_t;
    mmode_t      m_mode;
    int          m_next, m_age, e_adrs;
    logic [31:0] m_sum, e_data;
    logic        e_we;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        h;
        logic [10:0] st;
        logic        we;
        logic [10:0] a;
        logic        cpu;
        logic        er;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_next = 0; m_age = 0; m_sum = '0; e_we = 1'b0;
    endtask

    // expected effect of one rising edge given the inputs held during the preceding cycle
    task automatic model_edge(input logic v, input logic [31:0] d, input logic l,
                              input logic h, input logic [10:0] st);
        int a;
        logic [31:0] base;
        e_we = 1'b0;
        if (h) begin
            m_mode = M_IDLE; m_next = 0; m_sum = '0;
        end else if (m_mode == M_IDLE || m_mode == M_LOAD) begin
            if (v) begin
                a    = (m_mode == M_IDLE) ? int'(st) : m_next;
                base = (m_mode == M_IDLE) ? 32'd0 : m_sum;
                if (CSUM && l) begin
                    m_mode = (d == base) ? M_RUN : M_ERR;
                    m_age  = 0;
                end else if (a >= DEP) begin
                    m_mode = M_ERR;
                end else begin
                    e_we = 1'b1; e_adrs = a; e_data = d;
                    m_next = a + 1;
                    m_sum  = base + d;
                    m_mode = l ? M_RUN : M_LOAD;
                    m_age  = 0;
                end
            end
        end else if (m_mode == M_RUN) begin
            m_age++;
        end
    endtask

    task automatic check_outs();
        logic run_up;
        run_up = (m_mode == M_RUN) && (m_age >= 1);
        chk("w_enable", 64'(w_enable), 64'(e_we));
        if (e_we) begin
            chk("w_adrs", 64'(w_adrs), 64'(e_adrs));
            chk("w_instruction", 64'(w_instruction), 64'(e_data));
        end
        chk("cpu_en", 64'(cpu_en), 64'(run_up));
        chk("done", 64'(done), 64'(run_up));
        chk("busy", 64'(busy), 64'(m_mode == M_LOAD));
        chk("err", 64'(err), 64'(m_mode == M_ERR));
        chk("s_ready", 64'(s_ready), 64'(m_mode == M_IDLE || m_mode == M_LOAD));
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic h, input logic [10:0] st);
        s_valid = v; s_data = d; s_last = l; halt_req = h; cfg_start_adrs = st;
        @(posedge clk);
        model_edge(v, d, l, h, st);
        #1;
        check_outs();
    endtask

    task automatic async_reset();
        s_valid = 1'b0; s_last = 1'b0; halt_req = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_w_enable", 64'(w_enable), 64'd0);
        chk("rst_w_adrs", 64'(w_adrs), 64'd0);
        chk("rst_w_instr", 64'(w_instruction), 64'd0);
        chk("rst_cpu_en", 64'(cpu_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0, 11'd0);
    endtask

    initial begin
        int prev_a;
        bit have_a;
        logic        rv, rl, rh;
        logic [31:0] rd;
        logic [10:0] rst_a;

        model_reset();
        async_reset();

`ifdef PROG_LOADER_CSUM_EN
        tbl.push_back('{1, 32'h1, 0, 0, 11'd0, 1, 11'd0, 0, 0});
        tbl.push_back('{1, 32'h2, 0, 0, 11'd0, 1, 11'd1, 0, 0});
        tbl.push_back('{1, 32'h3, 1, 0, 11'd0, 0, 11'd0, 0, 0});
        tbl.push_back('{0, 32'h0, 0, 0, 11'd0, 0, 11'd0, 1, 0});
        tbl.push_back('{0, 32'h0, 0, 1, 11'd0, 0, 11'd0, 0, 0});
        tbl.push_back('{1, 32'h1, 0, 0, 11'd0, 1, 11'd0, 0, 0});
        tbl.push_back('{1, 32'h2, 0, 0, 11'd0, 1, 11'd1, 0, 0});
        tbl.push_back('{1, 32'h4, 1, 0, 11'd0, 0, 11'd0, 0, 1});
        tbl.push_back('{0, 32'h0, 0, 0, 11'd0, 0, 11'd0, 0, 1});
`else
        tbl.push_back('{1, 32'hE0000C07, 0, 0, 11'd1, 1, 11'd1, 0, 0});
        tbl.push_back('{1, 32'hE0230007, 0, 0, 11'd1, 1, 11'd2, 0, 0});
        tbl.push_back('{1, 32'hC07FF003, 1, 0, 11'd1, 1, 11'd3, 0, 0});
        tbl.push_back('{0, 32'h0,        0, 0, 11'd1, 0, 11'd0, 1, 0});
        tbl.push_back('{0, 32'h0,        0, 0, 11'd1, 0, 11'd0, 1, 0});
`endif
        tbl.push_back('{0, 32'h0, 0, 1, 11'd0, 0, 11'd0, 0, 0});
        tbl.push_back('{1, 32'hA, 0, 0, 11'd2045, 1, 11'd2045, 0, 0});
        tbl.push_back('{1, 32'hB, 0, 0, 11'd2045, 1, 11'd2046, 0, 0});
        tbl.push_back('{1, 32'hC, 0, 0, 11'd2045, 1, 11'd2047, 0, 0});
        tbl.push_back('{1, 32'hD, 0, 0, 11'd2045, 0, 11'd0,    0, 1});
        tbl.push_back('{0, 32'h0, 0, 0, 11'd2045, 0, 11'd0,    0, 1});
        tbl.push_back('{0, 32'h0, 0, 1, 11'd0,    0, 11'd0,    0, 0});

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].h, tbl[i].st);
            chk($sformatf("tbl%0d_we", i), 64'(w_enable), 64'(tbl[i].we));
            if (tbl[i].we) chk($sformatf("tbl%0d_adrs", i), 64'(w_adrs), 64'(tbl[i].a));
            chk($sformatf("tbl%0d_cpu_en", i), 64'(cpu_en), 64'(tbl[i].cpu));
            chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].er));
        end

        // valid toggled every other cycle: writes trail transfers by one, addresses contiguous
        have_a = 1'b0; prev_a = 0;
        for (int i = 0; i < 10; i++) begin
            step((i % 2) == 0, $urandom, 1'b0, 1'b0, 11'd100);
            chk("toggle_we", 64'(w_enable), 64'((i % 2) == 0));
            if (w_enable) begin
                if (have_a) chk("toggle_contig", 64'(w_adrs), 64'(prev_a + 1));
                else        chk("toggle_first", 64'(w_adrs), 64'd100);
                prev_a = int'(w_adrs); have_a = 1'b1;
            end
        end

        // halt and transfer in the same LOAD cycle: the word is dropped
        step(1'b1, 32'h55, 1'b0, 1'b1, 11'd0);
        step(1'b1, 32'h11, 1'b0, 1'b0, 11'd10);
        step(1'b1, 32'h22, 1'b0, 1'b1, 11'd10);
        chk("halt_no_write", 64'(w_enable), 64'd0);
        chk("halt_idle", 64'(s_ready && !busy), 64'd1);
        chk("halt_cpu_en", 64'(cpu_en), 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 11'd10);

        // reset in the middle of a load, then restart from the configured address
        step(1'b1, 32'h33, 1'b0, 1'b0, 11'd50);
        step(1'b1, 32'h44, 1'b0, 1'b0, 11'd50);
        async_reset();
        chk("post_rst_we", 64'(w_enable), 64'd0);
        step(1'b1, 32'h66, 1'b0, 1'b0, 11'd300);
        chk("restart_adrs", 64'(w_adrs), 64'd300);
        step(1'b0, 32'h0, 1'b0, 1'b1, 11'd0);

        for (int i = 0; i < 3000; i++) begin
            rh = ($urandom_range(0, 39) == 0);
            rv = ($urandom_range(0, 9) < 6);
            rl = ($urandom_range(0, 11) == 0);
            rd = $urandom;
            case ($urandom_range(0, 2))
                0:       rst_a = 11'($urandom_range(2040, 2047));
                1:       rst_a = 11'($urandom_range(0, 15));
                default: rst_a = 11'($urandom);
            endcase
            if (CSUM && rl && $urandom_range(0, 1) == 1)
                rd = (m_mode == M_LOAD) ? m_sum : 32'd0;
            step(rv, rd, rl, rh, rst_a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
